age_priority_arbiter: RTL and testbench
=======================================

AGE_PRIORITY_ARBITER -- requirements
Module: age_priority_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, >= 1.
REQ-002 Parameter PRIORITY_WIDTH, default 4: width of each static priority.
REQ-003 Parameter AGE_WIDTH, default 4: width of each per-requester age counter.
REQ-004 Parameter INDEX_WIDTH, default (N == 1) ? 1 : $clog2(N): width of the grant index.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_request  input  N  request bit per requester.
REQ-008 i_priority  input  N x PRIORITY_WIDTH  static priority per requester; larger value is more urgent.
REQ-009 i_release  input  1  granted requester has finished with the shared resource.
REQ-010 o_grant_valid  output  1  a grant is held.
REQ-011 o_grant  output  N  one-hot grant; all zero when o_grant_valid = 0.
REQ-012 o_grant_index  output  INDEX_WIDTH  index of the granted requester; zero when o_grant_valid = 0.

Function
REQ-013 The FSM SHALL have two states, IDLE and BUSY.
REQ-014 IDLE with no i_request bit set SHALL remain IDLE.
REQ-015 IDLE with any i_request bit set SHALL arbitrate combinationally, register the winner and enter BUSY, giving o_grant_valid = 1 one cycle after the sampled request.
REQ-016 Effective priority SHALL be the saturating sum of i_priority[i] and age[i], clipped to 2**PRIORITY_WIDTH-1.
REQ-017 The compared value per requester SHALL be {i_request[i], effective[i]}, so any requester beats any non-requester.
REQ-018 Among equal compared values, the lowest index SHALL win.
REQ-019 BUSY SHALL hold o_grant, o_grant_index and o_grant_valid stable, ignoring i_request and i_priority changes, until i_release is sampled high.
REQ-020 On i_release sampled high in BUSY, the next state SHALL be IDLE, with outputs zero from the following cycle.
REQ-021 The earliest re-grant SHALL be two cycles after i_release is sampled.
REQ-022 i_release SHALL be ignored in IDLE.
REQ-023 Withdrawal of the granted request during BUSY SHALL NOT end the grant; only i_release ends it.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately force IDLE, all outputs to zero and all age counters to zero, including mid-grant.
REQ-025 Deassertion SHALL take effect at the next i_clk edge; no grant SHALL issue earlier than one cycle after deassertion.

Configuration
REQ-026 Macro AGE_PRIORITY_ARBITER_AGING_EN SHALL compile aging in or out.
REQ-027 With the macro defined, at each IDLE->BUSY transition:
  - each requesting non-winner's age SHALL increment, saturating at 2**AGE_WIDTH-1;
  - the winner's age SHALL clear to zero;
  - a non-requester's age SHALL clear to zero.
REQ-028 Without the macro defined, no age registers SHALL exist, age SHALL be treated as zero, and effective priority SHALL equal i_priority.

Structure
REQ-029 Package age_priority_arbiter_pkg SHALL hold the state enum (IDLE, BUSY) and the saturating-add function.
REQ-030 Winner selection SHALL instantiate the existing max_finder module:
  - VALUE_WIDTH = PRIORITY_WIDTH+1;
  - N = N;
  - INDEX_WIDTH taken from its result.
REQ-031 The one-hot o_grant SHALL be decoded from the registered index.

Verification (N=4, PRIORITY_WIDTH=4, AGE_WIDTH=4)
REQ-032 Reset: hold i_rst_n=0 with requests active -> o_grant_valid=0, o_grant=4'b0000, o_grant_index=0; assert reset mid-BUSY -> outputs zero without waiting for a clock edge.
REQ-033 Single request: i_request=4'b0100, priority 5 at cycle 0 -> cycle 1: o_grant=4'b0100, o_grant_index=2. Grant holds through a request drop; i_release at cycle 4 -> outputs zero at cycle 5.
REQ-034 Tie: i_request=4'b1010, priorities 7 -> o_grant_index=1.
REQ-035 Aging, macro defined: requester 0 priority 3 and requester 1 priority 6 request continuously, each grant released after one cycle:
  - requester 1 wins three times while age[0] goes 1, 2, 3;
  - the fourth arbitration ties at 6 and grants index 0.
  Same stimulus with macro undefined -> index 1 always.
REQ-036 Saturation: priority 15, age driven to 15 by repeated losses -> effective stays 15, age stays 15, no wrap.
REQ-037 Re-grant timing: i_release sampled at cycle t with requests pending -> o_grant_valid=0 at t+1 and =1 at t+2.

Source files
------------

// File: rtl/age_priority_arbiter_pkg.sv
// Shared types and helpers for the age/priority arbiter.
package age_priority_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Saturating add on 32-bit operands; callers truncate to their field width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/age_priority_arbiter_max_finder.sv
// Generic max_finder: index of the largest of N packed values, lowest index on ties.
module max_finder #(
  parameter int VALUE_WIDTH = 5,
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [N*VALUE_WIDTH-1:0] i_values,
  output logic [INDEX_WIDTH-1:0]   o_index
);

  logic [VALUE_WIDTH-1:0] best_v;

  // Strict greater-than keeps the earliest index when values are equal.
  always_comb begin
    best_v  = i_values[VALUE_WIDTH-1:0];
    o_index = '0;
    for (int i = 1; i < N; i++) begin
      if (i_values[i*VALUE_WIDTH +: VALUE_WIDTH] > best_v) begin
        best_v  = i_values[i*VALUE_WIDTH +: VALUE_WIDTH];
        o_index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/age_priority_arbiter.sv
// Two-state arbiter granting by static priority plus age; holds the grant until i_release.
// Aging is compiled in with AGE_PRIORITY_ARBITER_AGING_EN; otherwise age is constant zero.
module age_priority_arbiter
  import age_priority_arbiter_pkg::*;
#(
  parameter int N              = 4,
  parameter int PRIORITY_WIDTH = 4,
  parameter int AGE_WIDTH      = 4,
  parameter int INDEX_WIDTH    = (N == 1) ? 1 : $clog2(N)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N-1:0]                i_request,
  input  logic [N*PRIORITY_WIDTH-1:0] i_priority,
  input  logic                        i_release,
  output logic                        o_grant_valid,
  output logic [N-1:0]                o_grant,
  output logic [INDEX_WIDTH-1:0]      o_grant_index
);

  localparam int EFF_MAX = (1 << PRIORITY_WIDTH) - 1;
  localparam int CMP_W   = PRIORITY_WIDTH + 1;

  state_e                              state_q, state_d;
  logic   [INDEX_WIDTH-1:0]            idx_q, idx_d;
  logic   [INDEX_WIDTH-1:0]            win_idx;
  logic                                arb_fire;
  logic   [N-1:0][AGE_WIDTH-1:0]       age;
  logic   [N-1:0][PRIORITY_WIDTH-1:0]  eff;
  logic   [N*CMP_W-1:0]                cmp_vals;

  // Request bit on top so any requester outranks every idle lane.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign eff[g] = PRIORITY_WIDTH'(sat_add(32'(i_priority[g*PRIORITY_WIDTH +: PRIORITY_WIDTH]),
                                            32'(age[g]), 32'(EFF_MAX)));
    assign cmp_vals[g*CMP_W +: CMP_W] = {i_request[g], eff[g]};
  end

  max_finder #(
    .VALUE_WIDTH (CMP_W),
    .N           (N),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_max_finder (
    .i_values (cmp_vals),
    .o_index  (win_idx)
  );

  assign arb_fire = (state_q == IDLE) && (|i_request);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (arb_fire) begin
          state_d = BUSY;
          idx_d   = win_idx;
        end
      end
      BUSY: begin
        if (i_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef AGE_PRIORITY_ARBITER_AGING_EN
  localparam int AGE_MAX = (1 << AGE_WIDTH) - 1;

  logic [N-1:0][AGE_WIDTH-1:0] age_q, age_d;

  // Ages move only on an IDLE->BUSY arbitration: losers that requested grow, all else clears.
  always_comb begin
    age_d = age_q;
    if (arb_fire) begin
      for (int i = 0; i < N; i++) begin
        if (i_request[i] && (INDEX_WIDTH'(i) != win_idx))
          age_d[i] = AGE_WIDTH'(sat_add(32'(age_q[i]), 32'd1, 32'(AGE_MAX)));
        else
          age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) age_q <= '0;
    else          age_q <= age_d;
  end

  assign age = age_q;
`else
  assign age = '0;
`endif

  // Outputs derive from the state register, so async reset clears them at once.
  assign o_grant_valid = (state_q == BUSY);
  assign o_grant_index = o_grant_valid ? idx_q : '0;
  assign o_grant       = o_grant_valid ? (N'(1) << idx_q) : '0;

endmodule

// File: tb/tb_age_priority_arbiter.sv
// Scoreboard bench for age_priority_arbiter (N=4, PRIORITY_WIDTH=4, AGE_WIDTH=4).
module tb_age_priority_arbiter;

`ifdef AGE_PRIORITY_ARBITER_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] prio;
  logic        rel;
  logic        o_grant_valid;
  logic [3:0]  o_grant;
  logic [1:0]  o_grant_index;

  int n_vec = 0;
  int n_err = 0;

  int m_age[4];
  bit m_busy;
  bit prev_v;
  int exp_q[$];

  age_priority_arbiter #(
    .N(4), .PRIORITY_WIDTH(4), .AGE_WIDTH(4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_request     (req),
    .i_priority    (prio),
    .i_release     (rel),
    .o_grant_valid (o_grant_valid),
    .o_grant       (o_grant),
    .o_grant_index (o_grant_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_prio(input int i, input logic [3:0] v);
    prio[i*4 +: 4] = v;
  endtask

  function automatic int model_winner();
    int best, bestv, e, v;
    best  = 0;
    bestv = -1;
    for (int i = 0; i < 4; i++) begin
      e = int'(prio[i*4 +: 4]) + m_age[i];
      if (e > 15) e = 15;
      v = req[i] ? 16 + e : e;
      if (v > bestv) begin
        bestv = v;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    prev_v = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_age[i] = 0;
  endtask

  // Advance one clock: update the model from the inputs the DUT is about to sample, then check.
  task automatic step();
    int w;
    int e;
    if (!m_busy) begin
      if (|req) begin
        w = model_winner();
        exp_q.push_back(w);
        if (AGING) begin
          for (int i = 0; i < 4; i++) begin
            if (req[i] && i != w) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
            else                  m_age[i] = 0;
          end
        end
        m_busy = 1'b1;
      end
    end else if (rel) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(o_grant_valid), 32'(m_busy));
    if (o_grant_valid && !prev_v) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_index", 32'(o_grant_index), 32'(e));
        chk("sb_onehot", 32'(o_grant), 32'(1) << e);
      end
    end else if (!o_grant_valid) begin
      chk("idle_grant", 32'(o_grant), 32'd0);
      chk("idle_index", 32'(o_grant_index), 32'd0);
    end
    prev_v = o_grant_valid;
  endtask

  initial begin
    model_reset();
    rel   = 1'b0;
    req   = 4'b1111;
    prio  = 16'h1234;
    rst_n = 1'b0;

    // Reset held with requests active
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_grant_valid), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_index", 32'(o_grant_index), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("deassert_valid", 32'(o_grant_valid), 32'd0);
    step();
    chk("post_rst_index", 32'(o_grant_index), 32'd0);
    rel = 1'b1; req = 4'b0000;
    step();
    rel = 1'b0;

    // Single request, held through request drop, then released
    prio = '0; set_prio(2, 4'd5); req = 4'b0100;
    step();
    chk("single_index", 32'(o_grant_index), 32'd2);
    chk("single_grant", 32'(o_grant), 32'b0100);
    req = 4'b0000; prio = 16'hFFFF;
    step();
    step();
    chk("single_hold", 32'(o_grant), 32'b0100);
    rel = 1'b1;
    step();
    rel = 1'b0;
    chk("single_released", 32'(o_grant_valid), 32'd0);

    // Release while idle does nothing
    rel = 1'b1;
    step();
    rel = 1'b0;

    // Tie resolves to lowest index
    prio = '0; set_prio(1, 4'd7); set_prio(3, 4'd7); req = 4'b1010;
    step();
    chk("tie_index", 32'(o_grant_index), 32'd1);
    rel = 1'b1; req = 4'b0000;
    step();
    rel = 1'b0;

    // Aging sequence with re-grant gap
    prio = '0; set_prio(0, 4'd3); set_prio(1, 4'd6); req = 4'b0011;
    for (int r = 0; r < 4; r++) begin
      step();
      chk("age_index", 32'(o_grant_index), (AGING && r == 3) ? 32'd0 : 32'd1);
      rel = 1'b1;
      step();
      chk("regrant_gap", 32'(o_grant_valid), 32'd0);
      rel = 1'b0;
    end

    // Drive requester 1 age to saturation by repeated losses
    prio = '0; set_prio(0, 4'd15); set_prio(1, 4'd0); req = 4'b0011;
    for (int r = 0; r < 20; r++) begin
      step();
      chk("sat_index", 32'(o_grant_index), 32'd0);
      rel = 1'b1;
      step();
      rel = 1'b0;
    end

    // Saturated age plus priority must clip, not wrap
    prio = '0; set_prio(1, 4'd8); set_prio(2, 4'd14); req = 4'b0110;
    step();
    chk("clip_index", 32'(o_grant_index), AGING ? 32'd1 : 32'd2);
    rel = 1'b1; req = 4'b0000;
    step();
    rel = 1'b0;

    // Reset asserted mid-grant clears outputs without a clock edge
    prio = '0; req = 4'b1000;
    step();
    chk("midrst_pre", 32'(o_grant_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_grant_valid), 32'd0);
    chk("midrst_grant", 32'(o_grant), 32'd0);
    chk("midrst_index", 32'(o_grant_index), 32'd0);
    model_reset();
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
